pulse_stretcher: RTL and testbench

//  Converse of the rising-edge pulse detector: turns 1-cycle request pulses on din

---
 rtl/pulse_stretcher.sv | 145 ++++++++++++++
 tb/tb_pulse_stretcher.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// Turns single-cycle request pulses on din into HIGH_CYCLES-wide phases on dout, each
// followed by a GAP_CYCLES low guard. Requests that arrive while busy are queued up to MAX_PEND.
module pulse_stretcher #(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int MAX_PEND    = 3,
  parameter int RETRIGGER   = 0,
  localparam int PW         = $clog2(MAX_PEND + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          din,
  output logic          dout,
  output logic          busy,
  output logic [PW-1:0] pend_cnt,
  output logic          ovf
);

  localparam int MAXC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] H_LOAD   = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] G_LOAD   = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);
  localparam bit            RETRIG   = (RETRIGGER != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   pend_q, pend_d;
  logic            ovf_d;
  logic            enq;
  logic            dout_q, busy_q, ovf_q;

  function automatic logic [PW-1:0] pend_inc_sat(input logic [PW-1:0] p);
    return (p == PEND_MAX) ? p : p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] pend_dec_sat(input logic [PW-1:0] p);
    return (p == '0) ? p : p - PW'(1);
  endfunction

  function automatic logic [CW-1:0] cnt_dec(input logic [CW-1:0] c);
    return (c == '0) ? c : c - CW'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = 1'b0;
    enq     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (din) begin
          state_d = S_HIGH;
          cnt_d   = H_LOAD;
        end
      end

      S_HIGH: begin
        if (din && RETRIG) begin
          // Retrigger extends the current phase, even on its final cycle.
          cnt_d = H_LOAD;
        end else begin
          enq = din;
          if (cnt_q != '0) begin
            cnt_d = cnt_dec(cnt_q);
          end else begin
            state_d = S_GAP;
            cnt_d   = G_LOAD;
          end
        end
      end

      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_dec(cnt_q);
          enq   = din;
        end else if (pend_q != '0) begin
          // One queued request is served; a simultaneous din takes its slot.
          state_d = S_HIGH;
          cnt_d   = H_LOAD;
          pend_d  = din ? pend_q : pend_dec_sat(pend_q);
        end else if (din) begin
          state_d = S_HIGH;
          cnt_d   = H_LOAD;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (enq) begin
      if (pend_q < PEND_MAX) begin
        pend_d = pend_inc_sat(pend_q);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      dout_q  <= (state_d == S_HIGH);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign dout     = dout_q;
  assign busy     = busy_q;
  assign pend_cnt = pend_q;
  assign ovf      = ovf_q;

`ifndef SYNTHESIS
  a_pend_bound: assert property (@(posedge clk) disable iff (!resetn) pend_q <= PEND_MAX);
  a_ovf_full:   assert property (@(posedge clk) disable iff (!resetn) ovf_q |-> (pend_q == PEND_MAX));
  a_dout_state: assert property (@(posedge clk) disable iff (!resetn) dout_q == (state_q == S_HIGH));
  a_busy_state: assert property (@(posedge clk) disable iff (!resetn) busy_q == (state_q != S_IDLE));
`endif

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: a timeline model predicts every output cycle for a
// queuing instance and a retriggering instance; a monitor pops and compares after each edge.
module tb_pulse_stretcher;

  localparam int H  = 3;
  localparam int G  = 2;
  localparam int MP = 2;
  localparam int PW = $clog2(MP + 1);

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          din = 1'b0;
  logic          dout0, busy0, ovf0;
  logic          dout1, busy1, ovf1;
  logic [PW-1:0] pend0, pend1;

  pulse_stretcher #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .MAX_PEND(MP), .RETRIGGER(0)) u_q (
    .clk(clk), .resetn(resetn), .din(din), .dout(dout0), .busy(busy0), .pend_cnt(pend0), .ovf(ovf0)
  );

  pulse_stretcher #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .MAX_PEND(MP), .RETRIGGER(1)) u_r (
    .clk(clk), .resetn(resetn), .din(din), .dout(dout1), .busy(busy1), .pend_cnt(pend1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic dout;
    logic busy;
    logic ovf;
    int   pend;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t em;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit sb_on = 0;
  bit lb_on = 0;
  int nreq = 0;
  int nrise = 0;
  int lowrun = 100;
  logic prev0 = 1'b0;

  // Timeline model: current phase occupies cycles hs..he high, he+1..ge low guard.
  int hs[2];
  int he[2];
  int ge[2];
  int pm[2];

  task automatic check(input string nm, input int u, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s u%0d cyc %0d: got %0d expected %0d", nm, u, cyc, got, expv);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      hs[u] = 0;
      he[u] = -1;
      ge[u] = -1;
      pm[u] = 0;
    end
  endtask

  function automatic bit enqueue(input int u);
    if (pm[u] < MP) begin
      pm[u] = pm[u] + 1;
      return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void start_phase(input int u, input int k);
    hs[u] = k + 1;
    he[u] = k + H;
    ge[u] = k + H + G;
  endfunction

  // Request d sampled at edge k; returns the outputs expected for the cycle after edge k.
  task automatic model_step(input int u, input bit d, input int k, output exp_t e);
    bit ovf_n;
    bit act;
    bit inh;
    int c;
    ovf_n = 1'b0;
    act = (k >= hs[u]) && (k <= ge[u]);
    inh = act && (k <= he[u]);
    if (!act) begin
      if (d) start_phase(u, k);
    end else if (inh) begin
      if (d) begin
        if (u == 1) begin
          he[u] = k + H;
          ge[u] = k + H + G;
        end else begin
          ovf_n = enqueue(u);
        end
      end
    end else if (k == ge[u]) begin
      if (pm[u] > 0) begin
        start_phase(u, k);
        if (!d) pm[u] = pm[u] - 1;
      end else if (d) begin
        start_phase(u, k);
      end
    end else if (d) begin
      ovf_n = enqueue(u);
    end
    c = k + 1;
    e.dout = (c >= hs[u]) && (c <= he[u]);
    e.busy = (c >= hs[u]) && (c <= ge[u]);
    e.pend = pm[u];
    e.ovf  = ovf_n;
  endtask

  task automatic step(input bit d);
    exp_t e;
    @(negedge clk);
    din = d;
    model_step(0, d, cyc, e);
    q0.push_back(e);
    model_step(1, d, cyc, e);
    q1.push_back(e);
    if (lb_on && d) nreq++;
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0);
  endtask

  task automatic check_reset_state();
    check("rst_dout", 0, 32'(dout0), 0);
    check("rst_busy", 0, 32'(busy0), 0);
    check("rst_pend", 0, 32'(pend0), 0);
    check("rst_ovf",  0, 32'(ovf0),  0);
    check("rst_dout", 1, 32'(dout1), 0);
    check("rst_busy", 1, 32'(busy1), 0);
    check("rst_pend", 1, 32'(pend1), 0);
    check("rst_ovf",  1, 32'(ovf1),  0);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (sb_on && q0.size() > 0) begin
      em = q0.pop_front();
      check("dout", 0, 32'(dout0), 32'(em.dout));
      check("busy", 0, 32'(busy0), 32'(em.busy));
      check("pend", 0, 32'(pend0), 32'(em.pend));
      check("ovf",  0, 32'(ovf0),  32'(em.ovf));
    end
    if (sb_on && q1.size() > 0) begin
      em = q1.pop_front();
      check("dout", 1, 32'(dout1), 32'(em.dout));
      check("busy", 1, 32'(busy1), 32'(em.busy));
      check("pend", 1, 32'(pend1), 32'(em.pend));
      check("ovf",  1, 32'(ovf1),  32'(em.ovf));
    end
    if (dout0 && !prev0 && lb_on) begin
      nrise++;
      check("gap_before_edge", 0, 32'(lowrun >= G), 1);
    end
    lowrun = dout0 ? 0 : lowrun + 1;
    prev0  = dout0;
  end

  initial begin
    model_reset();
    #2;
    resetn = 1'b0;
    #1;
    check_reset_state();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    sb_on = 1'b1;

    // single request, back-to-back pair, held level with overflow, retrigger spacing
    step(1'b1); idle(10);
    step(1'b1); step(1'b1); idle(14);
    repeat (5) step(1'b1); idle(20);
    step(1'b1); step(1'b0); step(1'b1); idle(14);

    // asynchronous reset in the middle of a high phase
    step(1'b1); step(1'b0);
    #3;
    sb_on = 1'b0;
    resetn = 1'b0;
    #1;
    check_reset_state();
    q0.delete();
    q1.delete();
    model_reset();
    lowrun = 100;
    prev0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    sb_on = 1'b1;
    idle(8);

    // random requests, gated so the queuing instance never overflows
    lb_on = 1'b1;
    nreq = 0;
    nrise = 0;
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) < 20) && (pm[0] < MP));
    end
    idle(30);
    #2;
    lb_on = 1'b0;
    check("loopback_edges", 0, 32'(nrise), 32'(nreq));

    // a couple of random bursts that do overflow, then drain
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 99) < 60);
    end
    idle(30);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
